fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, width of FIFO read data and output stream data.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of the burst length field.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, burst request pulse, sampled only in IDLE.
REQ-006 SHALL have port burst_len, input, LEN_WIDTH, number of words to read, sampled with start.
REQ-007 SHALL have port fifo_empty, input, 1, empty flag from the FIFO.
REQ-008 SHALL have port fifo_data_out, input, FIFO_WIDTH, FIFO read data, valid one cycle after an accepted rd_en.
REQ-009 SHALL have port fifo_underflow, input, 1, underflow flag from the FIFO.
REQ-010 SHALL have port fifo_rd_en, output, 1, read enable to the FIFO.
REQ-011 SHALL have port m_valid, output, 1, output stream data valid.
REQ-012 SHALL have port m_ready, input, 1, output stream sink ready.
REQ-013 SHALL have port m_data, output, FIFO_WIDTH, output stream data.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at burst completion.
REQ-016 SHALL have port rd_count, output, 16, words delivered on the output stream (see Configuration).
REQ-017 SHALL have port underflow_err, output, 1, sticky underflow error (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-019 SHALL go IDLE->READ on start=1 with burst_len!=0, loading remaining=burst_len; start with burst_len=0 SHALL be ignored.
REQ-020 SHALL ignore start in every state except IDLE.
REQ-021 SHALL drive fifo_rd_en combinationally = (state==READ) && !fifo_empty && remaining!=0 && (occ + inflight - pop) < 2.
REQ-022 In REQ-021, occ is the skid-buffer occupancy (0..2), inflight is a register set the cycle after fifo_rd_en=1, and pop = m_valid && m_ready.
REQ-023 SHALL decrement remaining on every cycle with fifo_rd_en=1.
REQ-024 SHALL go READ->DRAIN on the cycle remaining reaches 0.
REQ-025 SHALL go DRAIN->DONE when occ==0 and inflight==0.
REQ-026 SHALL go DONE->IDLE unconditionally, with done=1 only in DONE.
REQ-027 SHALL capture fifo_data_out into a 2-entry in-order skid buffer on each cycle inflight=1.
REQ-028 SHALL assert m_valid from the registered buffer head; latency from fifo_rd_en to m_valid is 2 cycles.
REQ-029 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-030 SHALL sustain one word per cycle when m_ready=1 and fifo_empty=0.
REQ-031 SHALL update occ correctly when a capture and a pop occur in the same cycle.
REQ-032 SHALL never overflow the buffer, and SHALL never assert fifo_rd_en while fifo_empty=1.
REQ-033 SHALL keep READ and stall fifo_rd_en without error while fifo_empty=1 during a burst.

Reset
REQ-034 On rst_n=0 at a clk edge, SHALL set state=IDLE, remaining=0, occ=0, inflight=0.
REQ-035 On rst_n=0 at a clk edge, SHALL set fifo_rd_en=0, m_valid=0, m_data=0, busy=0, done=0, rd_count=0, underflow_err=0.
REQ-036 Reset mid-burst SHALL discard buffered and in-flight data, with no done pulse.

Configuration
REQ-037 With macro FIFO_RD_STATS_EN defined, SHALL increment rd_count (16-bit, wrapping 0xFFFF->0) on each pop.
REQ-038 With macro FIFO_RD_STATS_EN defined, SHALL set underflow_err on fifo_underflow=1 and hold it until reset.
REQ-039 With FIFO_RD_STATS_EN undefined, SHALL tie rd_count=0 and underflow_err=0 and omit their registers.

Verification
REQ-040 SHALL cover: FIFO holds 4 words A,B,C,D, start with burst_len=4, m_ready=1 -> fifo_rd_en high 4 consecutive cycles; m_valid 4 cycles starting 2 after first rd_en; data A,B,C,D; done 1 cycle; busy low next.
REQ-041 SHALL cover: burst_len=3, m_ready=0 for 10 cycles then 1 -> exactly 2 reads issued while stalled, m_data held at first word, third read after release, order preserved.
REQ-042 SHALL cover: FIFO holds 1 word, burst_len=3, second word written 5 cycles later -> no rd_en while fifo_empty=1, remaining words delivered as they arrive, done only after third pop.
REQ-043 SHALL cover: start with burst_len=0, and start while busy -> both ignored, with no state change.
REQ-044 SHALL cover: rst_n=0 mid-burst after 2 pops -> all outputs 0 next cycle, no done; a fresh burst of 2 then works.
REQ-045 SHALL cover, with FIFO_RD_STATS_EN: 0xFFFF prior pops then 1 pop -> rd_count=0; a fifo_underflow pulse -> underflow_err=1 until reset.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: pulls burst_len words from a FIFO into a 2-entry skid buffer
// and streams them out with valid/ready. Optional statistics under FIFO_RD_STATS_EN.
module fifo_rd_ctrl #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           rd_count,
  output logic                  underflow_err
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic                   inflight_q, inflight_d;
  logic [1:0]             occ_q, occ_d;
  logic [FIFO_WIDTH-1:0]  head_q, head_d;
  logic [FIFO_WIDTH-1:0]  tail_q, tail_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pop;
  logic [2:0]             level;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = head_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pop     = m_valid && m_ready;

  // Projected occupancy once the outstanding read lands and this cycle's pop retires.
  assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign fifo_rd_en = (state_q == StRead) && !fifo_empty &&
                      (remaining_q != '0) && (level < 3'd2);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (start && (burst_len != '0)) begin
          state_d     = StRead;
          remaining_d = burst_len;
        end
      end
      StRead: begin
        if (fifo_rd_en) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if ((occ_q == 2'd0) && !inflight_q) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = fifo_rd_en;
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    if (pop) head_d = tail_q;
    // Landing slot is computed after the pop has shifted the buffer.
    if (inflight_q) begin
      if ((occ_q - {1'b0, pop}) == 2'd0) head_d = fifo_data_out;
      else                               tail_d = fifo_data_out;
    end
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic        underflow_err_q, underflow_err_d;

  always_comb begin
    rd_count_d      = pop ? rd_count_q + 16'd1 : rd_count_q;
    underflow_err_d = underflow_err_q | fifo_underflow;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count_q      <= 16'd0;
      underflow_err_q <= 1'b0;
    end else begin
      rd_count_q      <= rd_count_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign rd_count      = rd_count_q;
  assign underflow_err = underflow_err_q;
`else
  logic unused_underflow;
  assign unused_underflow = fifo_underflow;
  assign rd_count         = 16'd0;
  assign underflow_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a FIFO model feeds the DUT, a negedge monitor
// pops expected words as the stream delivers them; directed checks cover control.
module tb_fifo_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  burst_len;
  logic        fifo_empty;
  logic [15:0] fifo_data_out;
  logic        fifo_underflow;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        busy;
  logic        done;
  logic [15:0] rd_count;
  logic        underflow_err;

  fifo_rd_ctrl #(.FIFO_WIDTH(16), .LEN_WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .burst_len     (burst_len),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .busy          (busy),
    .done          (done),
    .rd_count      (rd_count),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  // FIFO model
  logic [15:0] mem [1024];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        fifo_clr = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_data_out <= mem[rd_ptr % 1024];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  int          vec = 0;
  int          miss = 0;
  int          pop_cnt = 0;
  int          rd_issued = 0;
  logic [15:0] exp_q [$];

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_issued++;
      vec++;
      if (fifo_empty) begin
        miss++;
        $display("FAIL rd_en_while_empty: fifo_rd_en=1 with fifo_empty=1 at %0t", $time);
      end
    end
    if (m_valid && m_ready) begin
      pop_cnt++;
      vec++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL unexpected_pop: got %0h, expected no word", m_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          miss++;
          $display("FAIL stream_data: got %0h expected %0h", m_data, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [15:0] w, input bit expect_it);
    mem[wr_ptr % 1024] = w;
    wr_ptr++;
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic start_burst(input logic [7:0] n);
    start     = 1'b1;
    burst_len = n;
    tick();
    start     = 1'b0;
    burst_len = 8'd0;
  endtask

  task automatic wait_done(input string name, input int p0, input int npops);
    for (int k = 0; k < 3000 && !done; k++) tick();
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_pops_at_done"}, pop_cnt - p0, npops);
    tick();
    chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic flush_fifo();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
  endtask

  initial begin
    logic [11:0] rd_tr, vl_tr, dn_tr, by_tr;
    int          p0, r0, nrd, cur, n;
    bit          held_ok;

    rst_n = 1'b0; start = 1'b0; burst_len = 8'd0; m_ready = 1'b0; fifo_underflow = 1'b0;
    tick(); tick();
    chk("reset_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("reset_m_valid", {31'd0, m_valid}, 0);
    chk("reset_m_data", {16'd0, m_data}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_rd_count", {16'd0, rd_count}, 0);
    chk("reset_underflow_err", {31'd0, underflow_err}, 0);
    rst_n = 1'b1;
    tick();

    // Basic 4-word burst, sink always ready
    m_ready = 1'b1;
    put(16'hA00A, 1); put(16'hB00B, 1); put(16'hC00C, 1); put(16'hD00D, 1);
    start_burst(8'd4);
    for (int i = 0; i < 12; i++) begin
      rd_tr[i] = fifo_rd_en; vl_tr[i] = m_valid; dn_tr[i] = done; by_tr[i] = busy;
      tick();
    end
    chk("b4_rd_en_trace", {20'd0, rd_tr}, 32'h00F);
    chk("b4_m_valid_trace", {20'd0, vl_tr}, 32'h03C);
    chk("b4_done_trace", {20'd0, dn_tr}, 32'h080);
    chk("b4_busy_trace", {20'd0, by_tr}, 32'h0FF);

    // Sink stalled for 10 cycles
    m_ready = 1'b0;
    put(16'hE00E, 1); put(16'hF00F, 1); put(16'h1234, 1);
    p0 = pop_cnt;
    start_burst(8'd3);
    nrd = 0; held_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (fifo_rd_en) nrd++;
      if (m_valid && (m_data !== 16'hE00E)) held_ok = 1'b0;
      tick();
    end
    chk("stall_reads", nrd, 2);
    chk("stall_hold", {31'd0, held_ok}, 1);
    chk("stall_valid", {31'd0, m_valid}, 1);
    m_ready = 1'b1;
    #1;
    chk("stall_third_read", {31'd0, fifo_rd_en}, 1);
    wait_done("stall", p0, 3);

    // FIFO runs dry mid-burst
    put(16'h5501, 1);
    p0 = pop_cnt;
    start_burst(8'd3);
    for (int i = 0; i < 5; i++) tick();
    chk("dry_busy", {31'd0, busy}, 1);
    chk("dry_rd_en", {31'd0, fifo_rd_en}, 0);
    put(16'h5502, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("dry_pops_mid", pop_cnt - p0, 2);
    chk("dry_not_done", {31'd0, done}, 0);
    put(16'h5503, 1);
    wait_done("dry", p0, 3);

    // Zero-length start and start while busy are ignored
    start = 1'b1; burst_len = 8'd0;
    tick();
    start = 1'b0;
    chk("zero_len_busy", {31'd0, busy}, 0);
    tick();
    chk("zero_len_rd_en", {31'd0, fifo_rd_en}, 0);
    put(16'h6601, 1); put(16'h6602, 1); put(16'h6603, 0);
    p0 = pop_cnt; r0 = rd_issued;
    start_burst(8'd2);
    start = 1'b1; burst_len = 8'd5;
    tick();
    start = 1'b0; burst_len = 8'd0;
    wait_done("busy_start", p0, 2);
    for (int i = 0; i < 3; i++) tick();
    chk("busy_start_reads", rd_issued - r0, 2);
    chk("busy_start_idle", {31'd0, busy}, 0);
    flush_fifo();

    // Reset in the middle of a burst after two pops
    put(16'h7701, 1); put(16'h7702, 1); put(16'h7703, 1); put(16'h7704, 1);
    p0 = pop_cnt;
    start_burst(8'd4);
    for (int k = 0; k < 50 && (pop_cnt - p0) < 2; k++) tick();
    chk("midrst_pops", pop_cnt - p0, 2);
    rst_n = 1'b0; m_ready = 1'b0;
    tick();
    chk("midrst_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("midrst_m_valid", {31'd0, m_valid}, 0);
    chk("midrst_m_data", {16'd0, m_data}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_rd_count", {16'd0, rd_count}, 0);
    chk("midrst_underflow_err", {31'd0, underflow_err}, 0);
    rst_n = 1'b1;
    exp_q.delete();
    flush_fifo();
    chk("midrst_no_done", {31'd0, done}, 0);
    m_ready = 1'b1;
    put(16'h8801, 1); put(16'h8802, 1);
    p0 = pop_cnt;
    start_burst(8'd2);
    wait_done("post_rst", p0, 2);

`ifdef FIFO_RD_STATS_EN
    chk("stats_count_2", {16'd0, rd_count}, 2);
    cur = 2;
    while (cur < 65535) begin
      n = ((65535 - cur) > 255) ? 255 : (65535 - cur);
      for (int j = 0; j < n; j++) put(16'(j) ^ 16'h5A5A, 1);
      p0 = pop_cnt;
      start_burst(n[7:0]);
      wait_done("stats_pump", p0, n);
      cur += n;
    end
    chk("stats_count_ffff", {16'd0, rd_count}, 32'hFFFF);
    put(16'h9999, 1);
    p0 = pop_cnt;
    start_burst(8'd1);
    wait_done("stats_wrap", p0, 1);
    chk("stats_count_wrap", {16'd0, rd_count}, 0);
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    chk("underflow_set", {31'd0, underflow_err}, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("underflow_sticky", {31'd0, underflow_err}, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("underflow_cleared", {31'd0, underflow_err}, 0);
`else
    chk("nostats_count", {16'd0, rd_count}, 0);
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    tick();
    chk("nostats_underflow", {31'd0, underflow_err}, 0);
`endif

    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
